iir_coef_loader: RTL and testbench
==================================

Name: iir_coef_loader

Overview:
Upstream configuration stage for the cascaded IIR filter. It receives a framed 16-bit word stream over a valid/ready handshake and checks a header and checksum. It then atomically commits the coefficients b0,b1,b2,a1,a2,a3 and the order to the filter cascade. The filter is held in reset while a load is in progress and for a flush window afterwards.

Parameters:
FLUSH_CYCLES, 4, cycles filt_reset_n stays low after commit/abort; legal range 1..255
TIMEOUT, 1024, max idle cycles between accepted words before abort; legal range 1..65535
B_RST, 16'h0800, reset value of b0/b1/b2 (1.0 in Q4.11)
A_RST, 16'h0000, reset value of a1/a2/a3

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse that begins a load frame; ignored unless state is IDLE
load_valid  input  1  load_data is valid this cycle
load_data  input  16  frame word
load_ready  output  1  high in HDR, COEF, CSUM states
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: successful load fully applied
err  output  1  one-cycle pulse: frame aborted
filt_reset_n  output  1  active-low reset to filter cascade
b0, b1, b2, a1, a2, a3  output  16 each  committed coefficients, Q4.11 two's complement
order  output  4  committed filter order, 1..3

Behaviour:
- Reset (reset low, async): state IDLE; b* = B_RST; a* = A_RST; order = 4'd1; filt_reset_n = 0; load_ready, busy, done, err = 0. First cycle after release: filt_reset_n = 1.
- Word accept: load_valid && load_ready on a rising edge. load_data is don't-care otherwise.
- Frame format: header, then b0, b1, b2, a1, a2, a3, then checksum (8 words total).
  - Header [15:12] must be 4'hA. Header [3:0] = order, which must be 1..3. Header [11:4] is ignored.
  - Checksum = 16-bit wrap-around sum of the header and the 6 coefficient words.
- IDLE: load_ready = 0, filt_reset_n = 1. On start: go to HDR, drive filt_reset_n = 0 from the next cycle, clear the sum accumulator and the timeout counter.
- HDR: on accept:
  - Bad sync or order ∉ {1,2,3}: go to ABORT.
  - Otherwise: latch the order into a shadow register, add the word to the sum, go to COEF with index 0.
- COEF: on each accept, write shadow[index], add to the sum, increment the index (3-bit). After the accept at index 5, go to CSUM.
- CSUM: on accept:
  - Word == sum: go to COMMIT.
  - Otherwise: go to ABORT.
- COMMIT (1 cycle): copy all shadow registers to the outputs in the same edge; go to FLUSH with ok = 1.
- ABORT (1 cycle): err = 1; outputs keep their previous committed values; go to FLUSH with ok = 0.
- FLUSH: filt_reset_n stays 0 for exactly FLUSH_CYCLES cycles, then return to IDLE. On that return edge, filt_reset_n goes to 1, and done pulses only if ok = 1.
- Timeout: in HDR/COEF/CSUM the counter resets on every accept. If it reaches TIMEOUT, go to ABORT.
- Outputs never change outside the COMMIT edge or reset. A partial frame never changes the outputs.
- start while busy: ignored, no side effects.
- reset asserted mid-frame: immediate return to reset values. The shadow registers are discarded.
- load_valid held high in IDLE: no accept, no effect.

Decomposition:
- Shared package iir_pkg:
  - state enum {IDLE, HDR, COEF, CSUM, COMMIT, ABORT, FLUSH}
  - SYNC_NIBBLE = 4'hA, COEF_WORDS = 6
  - Q4.11 ONE = 16'h0800
  - ORDER_MIN = 1, ORDER_MAX = 3
- Sub-module iir_cfg_chk: the running 16-bit checksum accumulator plus the header validity check (sync and order range). The FSM, shadow registers and flush counter stay in the top module.

Test Plan:
- Good frame A002, 0800, 0400, 0200, 0100, 0080, 0040, AFC2 sent back-to-back -> outputs updated on the COMMIT edge; order = 2; filt_reset_n low from the cycle after start until 4 cycles after COMMIT; done pulses once; err = 0.
- Wrap-around sum: header A003, six words FFFF, checksum 9FFD -> commit; every coefficient = FFFF; order = 3.
- Wrong checksum (AFC3 in place of AFC2) -> err pulse; outputs remain at reset values (0800, 0800, 0800, 0000, 0000, 0000, order 1); no done; filt_reset_n high again after 4 flush cycles.
- Bad header (B002, then separately A004) -> abort right after the header accept; err pulse; no further words accepted.
- load_valid dropped for 1024 cycles after the third coefficient -> timeout abort with err; outputs unchanged. A second start pulse issued during busy is ignored.
- reset pulled low during COEF index 3 -> immediate reset values and IDLE. A following complete good frame commits correctly.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared types and constants for the IIR coefficient loader: FSM states,
// frame sync/order rules and the Q4.11 unity value.
package iir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        COEF,
        CSUM,
        COMMIT,
        ABORT,
        FLUSH
    } state_t;

    localparam logic [3:0]  SYNC_NIBBLE = 4'hA;
    localparam int          COEF_WORDS  = 6;
    localparam logic [15:0] Q411_ONE    = 16'h0800;
    localparam logic [3:0]  ORDER_MIN   = 4'd1;
    localparam logic [3:0]  ORDER_MAX   = 4'd3;

    // A header is usable when the sync nibble matches and the order is supported.
    function automatic logic hdr_ok(input logic [15:0] word);
        return (word[15:12] == SYNC_NIBBLE) &&
               (word[3:0] >= ORDER_MIN) &&
               (word[3:0] <= ORDER_MAX);
    endfunction

endpackage

// File: rtl/iir_cfg_chk.sv
// Running 16-bit wrap-around checksum of accepted frame words, plus the
// header validity and checksum-match decisions used by the loader FSM.
module iir_cfg_chk
    import iir_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        add,
    input  logic [15:0] word,
    output logic        hdr_valid,
    output logic        sum_match
);

    logic [15:0] sum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
        end else if (clear) begin
            sum_reg <= '0;
        end else if (add) begin
            sum_reg <= sum_reg + word;
        end
    end

    assign hdr_valid = hdr_ok(word);
    assign sum_match = (word == sum_reg);

endmodule

// File: rtl/iir_coef_loader.sv
// Framed coefficient loader: validates header/checksum, stages words in shadow
// registers and commits them atomically, holding the filter in reset meanwhile.
module iir_coef_loader
    import iir_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 4,
    parameter int          TIMEOUT      = 1024,
    parameter logic [15:0] B_RST        = Q411_ONE,
    parameter logic [15:0] A_RST        = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        filt_reset_n,
    output logic [15:0] b0,
    output logic [15:0] b1,
    output logic [15:0] b2,
    output logic [15:0] a1,
    output logic [15:0] a2,
    output logic [15:0] a3,
    output logic [3:0]  order
);

    state_t      state_reg;
    logic        load_ready_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;
    logic        filt_reset_n_reg;
    logic        ok_reg;
    logic [3:0]  order_reg;
    logic [3:0]  order_shadow_reg;
    logic [2:0]  idx_reg;
    logic [15:0] idle_cnt_reg;
    logic [7:0]  flush_cnt_reg;

    logic        accept;
    logic        hdr_valid;
    logic        sum_match;
    logic        chk_clear;
    logic        chk_add;
    logic        coef_wr;
    logic        commit;
    logic [15:0] coef_w [COEF_WORDS];

    assign accept    = load_valid && load_ready_reg;
    assign chk_clear = (state_reg == IDLE) && start;
    assign chk_add   = accept && (((state_reg == HDR) && hdr_valid) || (state_reg == COEF));
    assign coef_wr   = accept && (state_reg == COEF);
    assign commit    = (state_reg == COMMIT);

    iir_cfg_chk u_chk (
        .clk       (clk),
        .rst_n     (reset),
        .clear     (chk_clear),
        .add       (chk_add),
        .word      (load_data),
        .hdr_valid (hdr_valid),
        .sum_match (sum_match)
    );

    // Each coefficient has a staging copy; the visible copy only moves on COMMIT,
    // so a partial or rejected frame can never reach the filter.
    generate
        for (genvar gi = 0; gi < COEF_WORDS; gi++) begin : g_coef
            localparam logic [15:0] RST_VAL = (gi < 3) ? B_RST : A_RST;
            logic [15:0] shadow_reg;
            logic [15:0] coef_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    shadow_reg <= '0;
                    coef_reg   <= RST_VAL;
                end else begin
                    if (coef_wr && (idx_reg == 3'(gi))) begin
                        shadow_reg <= load_data;
                    end
                    if (commit) begin
                        coef_reg <= shadow_reg;
                    end
                end
            end

            assign coef_w[gi] = coef_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            load_ready_reg   <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
            filt_reset_n_reg <= 1'b0;
            ok_reg           <= 1'b0;
            order_reg        <= 4'd1;
            order_shadow_reg <= 4'd1;
            idx_reg          <= '0;
            idle_cnt_reg     <= '0;
            flush_cnt_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    filt_reset_n_reg <= 1'b1;
                    busy_reg         <= 1'b0;
                    load_ready_reg   <= 1'b0;
                    if (start) begin
                        state_reg        <= HDR;
                        filt_reset_n_reg <= 1'b0;
                        busy_reg         <= 1'b1;
                        load_ready_reg   <= 1'b1;
                        idle_cnt_reg     <= '0;
                    end
                end
                HDR, COEF, CSUM: begin
                    if (accept) begin
                        idle_cnt_reg <= '0;
                        case (state_reg)
                            HDR: begin
                                if (hdr_valid) begin
                                    order_shadow_reg <= load_data[3:0];
                                    idx_reg          <= '0;
                                    state_reg        <= COEF;
                                end else begin
                                    state_reg      <= ABORT;
                                    err_reg        <= 1'b1;
                                    load_ready_reg <= 1'b0;
                                end
                            end
                            COEF: begin
                                idx_reg <= idx_reg + 3'd1;
                                if (idx_reg == 3'(COEF_WORDS - 1)) begin
                                    state_reg <= CSUM;
                                end
                            end
                            default: begin
                                load_ready_reg <= 1'b0;
                                if (sum_match) begin
                                    state_reg <= COMMIT;
                                end else begin
                                    state_reg <= ABORT;
                                    err_reg   <= 1'b1;
                                end
                            end
                        endcase
                    end else if (idle_cnt_reg == 16'(TIMEOUT - 1)) begin
                        // TIMEOUT consecutive cycles without an accepted word
                        state_reg      <= ABORT;
                        err_reg        <= 1'b1;
                        load_ready_reg <= 1'b0;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + 16'd1;
                    end
                end
                COMMIT: begin
                    order_reg     <= order_shadow_reg;
                    ok_reg        <= 1'b1;
                    flush_cnt_reg <= '0;
                    state_reg     <= FLUSH;
                end
                ABORT: begin
                    ok_reg        <= 1'b0;
                    flush_cnt_reg <= '0;
                    state_reg     <= FLUSH;
                end
                FLUSH: begin
                    if (flush_cnt_reg == 8'(FLUSH_CYCLES - 1)) begin
                        state_reg        <= IDLE;
                        filt_reset_n_reg <= 1'b1;
                        busy_reg         <= 1'b0;
                        done_reg         <= ok_reg;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign load_ready   = load_ready_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign filt_reset_n = filt_reset_n_reg;
    assign order        = order_reg;
    assign b0           = coef_w[0];
    assign b1           = coef_w[1];
    assign b2           = coef_w[2];
    assign a1           = coef_w[3];
    assign a2           = coef_w[4];
    assign a3           = coef_w[5];

endmodule

// File: tb/tb_iir_coef_loader.sv
// Scoreboard bench for iir_coef_loader: stimulus pushes expected frame outcomes,
// a monitor pops and checks them whenever a frame finishes (busy falls).
module tb_iir_coef_loader;

    localparam int FLUSH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_ready, busy, done, err, filt_reset_n;
    logic [15:0] b0, b1, b2, a1, a2, a3;
    logic [3:0]  order;
    logic [5:0][15:0] dut_coef;

    iir_coef_loader #(
        .FLUSH_CYCLES (FLUSH),
        .TIMEOUT      (1024),
        .B_RST        (16'h0800),
        .A_RST        (16'h0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .filt_reset_n (filt_reset_n),
        .b0           (b0),
        .b1           (b1),
        .b2           (b2),
        .a1           (a1),
        .a2           (a2),
        .a3           (a3),
        .order        (order)
    );

    assign dut_coef = {a3, a2, a1, b2, b1, b0};

    always #5 clk = ~clk;

    typedef struct {
        bit               ok;
        logic [5:0][15:0] coef;
        logic [3:0]       ord;
        int               dur;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [5:0][15:0] m_coef;
    logic [3:0]       m_ord;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_coef = {16'h0000, 16'h0000, 16'h0000, 16'h0800, 16'h0800, 16'h0800};
        m_ord  = 4'd1;
    endtask

    // Reference: decide the frame outcome from the frame rules alone.
    task automatic push_expect(input logic [7:0][15:0] w, input int n_offer,
                               input bit untimed, output int exp_acc);
        exp_t e;
        int   s;
        bit   hdr_good;
        hdr_good = (w[0][15:12] == 4'hA) && (w[0][3:0] >= 4'd1) && (w[0][3:0] <= 4'd3);
        s = 0;
        for (int k = 0; k < 7; k++) s += int'(w[k]);
        e.ok = hdr_good && (n_offer == 8) && (w[7] == s[15:0]);
        exp_acc = hdr_good ? n_offer : 1;
        if (e.ok) begin
            for (int k = 0; k < 6; k++) m_coef[k] = w[k+1];
            m_ord = w[0][3:0];
        end
        e.coef = m_coef;
        e.ord  = m_ord;
        if (untimed || (hdr_good && n_offer < 8)) e.dur = 0;
        else e.dur = hdr_good ? (9 + FLUSH) : (2 + FLUSH);
        sb.push_back(e);
    endtask

    task automatic run_frame(input logic [7:0][15:0] w, input int n_offer, input bit gapped,
                             input int long_gap, input bit mid_start, input bit stop_early,
                             output int n_acc);
        int i, cyc, lg;
        i = 0; cyc = 0; lg = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc < 3000) begin
            if (!busy) break;
            if (stop_early && i == n_offer) break;
            start = mid_start && (cyc == 100);
            if (i == 3 && lg < long_gap) begin
                load_valid = 1'b0;
                lg++;
            end else if (i < n_offer && !(gapped && $urandom_range(0, 2) == 0)) begin
                load_valid = 1'b1;
                load_data  = w[i];
                if (load_ready) i++;
            end else begin
                load_valid = 1'b0;
            end
            if (!load_valid) load_data = 16'($urandom);
            @(negedge clk);
            cyc++;
        end
        load_valid = 1'b0;
        start = 1'b0;
        if (cyc >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_budget: busy still %0b after %0d cycles, expected idle", busy, cyc);
        end
        n_acc = i;
    endtask

    task automatic do_frame(input logic [7:0][15:0] w, input int n_offer, input bit gapped,
                            input int long_gap, input bit mid_start);
        int exp_acc, n_acc;
        push_expect(w, n_offer, gapped || (long_gap > 0), exp_acc);
        run_frame(w, n_offer, gapped, long_gap, mid_start, 1'b0, n_acc);
        chk("accepted_words", 64'(n_acc), 64'(exp_acc));
        repeat (2) @(negedge clk);
    endtask

    // Monitor: per-cycle invariants and per-frame scoreboard pop.
    initial begin : monitor
        bit   prev_busy, prev_rst;
        int   busy_cnt, err_cnt, frame_no;
        exp_t e;
        prev_busy = 0; prev_rst = 0; busy_cnt = 0; err_cnt = 0; frame_no = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_busy = 0; prev_rst = 0; busy_cnt = 0; err_cnt = 0;
            end else begin
                if (prev_rst) chk("filt_vs_busy", 64'(filt_reset_n), 64'(!busy));
                prev_rst = 1;
                if (busy) begin
                    busy_cnt++;
                    if (err) err_cnt++;
                    chk("done_while_busy", 64'(done), 64'(0));
                end else if (prev_busy) begin
                    chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        frame_no++;
                        $display("frame %0d: done=%0b err_pulses=%0d busy_cycles=%0d order=%0d coefs=%h",
                                 frame_no, done, err_cnt, busy_cnt, order, dut_coef);
                        chk("done_pulse", 64'(done), 64'(e.ok));
                        chk("err_pulses", 64'(err_cnt), 64'(e.ok ? 0 : 1));
                        chk("order", 64'(order), 64'(e.ord));
                        for (int k = 0; k < 6; k++) chk($sformatf("coef%0d", k), 64'(dut_coef[k]), 64'(e.coef[k]));
                        if (e.dur != 0) chk("busy_cycles", 64'(busy_cnt), 64'(e.dur));
                    end
                    busy_cnt = 0;
                    err_cnt = 0;
                end else begin
                    chk("idle_pulses", 64'({done, err}), 64'(0));
                end
                prev_busy = busy;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0][15:0] f;
        logic [15:0]      s;
        int               n;
        model_reset();

        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 6; k++) chk($sformatf("rst_coef%0d", k), 64'(dut_coef[k]), 64'(m_coef[k]));
        chk("rst_order", 64'(order), 64'(1));
        chk("rst_outputs", 64'({filt_reset_n, busy, load_ready, done, err}), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("filt_after_release", 64'(filt_reset_n), 64'(1));

        // valid held high while idle must be ignored
        repeat (6) begin
            load_valid = 1'b1;
            load_data = 16'($urandom);
            @(negedge clk);
            chk("idle_ready_busy", 64'({load_ready, busy}), 64'(0));
        end
        load_valid = 1'b0;

        f = {16'hAFC3, 16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'hA002};
        do_frame(f, 8, 0, 0, 0);
        f[7] = 16'hAFC2;
        do_frame(f, 8, 0, 0, 0);
        f = {16'h9FFD, {6{16'hFFFF}}, 16'hA003};
        do_frame(f, 8, 0, 0, 0);
        f = {16'hAFC2, 16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'hB002};
        do_frame(f, 8, 0, 0, 0);
        f[0] = 16'hA004;
        do_frame(f, 8, 0, 0, 0);
        f[0] = 16'hA000;
        do_frame(f, 8, 0, 0, 0);

        // timeout after the third coefficient, with a stray start while busy
        f = {16'h1234, 16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555, 16'h0666, 16'hA001};
        do_frame(f, 4, 0, 0, 1);
        repeat (5) begin
            @(negedge clk);
            chk("idle_after_timeout", 64'(busy), 64'(0));
        end

        // long but sub-timeout stall still commits
        f = {16'h0000, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060, 16'hA7F1};
        s = 16'(32'(f[0]) + 32'(f[1]) + 32'(f[2]) + 32'(f[3]) + 32'(f[4]) + 32'(f[5]) + 32'(f[6]));
        f[7] = s;
        do_frame(f, 8, 0, 500, 0);

        for (int r = 0; r < 14; r++) begin
            f[0] = {($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hA, 8'($urandom),
                    4'($urandom_range(0, 4))};
            for (int k = 1; k < 7; k++) f[k] = 16'($urandom);
            s = '0;
            for (int k = 0; k < 7; k++) s = s + f[k];
            f[7] = ($urandom_range(0, 3) == 0) ? (s ^ (16'd1 << $urandom_range(0, 15))) : s;
            do_frame(f, 8, 1'($urandom_range(0, 1)), 0, 0);
        end

        // reset in the middle of COEF index 3
        f = {16'hAFC2, 16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'hA002};
        run_frame(f, 4, 0, 0, 0, 1, n);
        #2 reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 6; k++) chk($sformatf("midrst_coef%0d", k), 64'(dut_coef[k]), 64'(m_coef[k]));
        chk("midrst_order", 64'(order), 64'(1));
        chk("midrst_outputs", 64'({filt_reset_n, busy, load_ready, done, err}), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("filt_after_midrst", 64'(filt_reset_n), 64'(1));
        do_frame(f, 8, 0, 0, 0);

        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
